// File: rtl/ra_pq_ctrl_if.sv
// ra_pq_ctrl_if: entry type plus the request/status bundle between front end and queue controller.
package pq_pkg;
    localparam int KW = 8;
    localparam int VW = 8;
    typedef struct packed {
        logic [KW-1:0] key;
        logic [VW-1:0] value;
    } kv_t;
endpackage

interface ra_pq_ctrl_if #(parameter int DEPTH = 8);
    import pq_pkg::*;
    localparam int CW = $clog2(DEPTH + 1);
    logic enq;
    logic deq;
    kv_t kvi;
    kv_t kvo;
    logic full;
    logic empty;
    logic [CW-1:0] count;
    logic ovf;
    logic udf;
    modport master (output enq, deq, kvi, input kvo, full, empty, count, ovf, udf);
    modport slave (input enq, deq, kvi, output kvo, full, empty, count, ovf, udf);
endinterface

// File: rtl/ra_pq_ctrl.sv
// ra_pq_ctrl: register-array priority queue, sorted descending by key, one enqueue/dequeue/replace per cycle.
module ra_pq_ctrl
    import pq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input logic clk,
    input logic rst,
    ra_pq_ctrl_if.slave pq
);
    localparam int CW = $clog2(DEPTH + 1);
    kv_t s [DEPTH];
    kv_t b [DEPTH];
    kv_t nx [DEPTH];
    logic [DEPTH-1:0] ahead;
    logic [CW-1:0] cnt;
    logic [CW-1:0] bc;
    logic ins;
    logic rem;
    logic rep;
    logic ovf_q;
    logic udf_q;
    always_comb begin
        ins = pq.enq && (pq.deq ? cnt == '0 : cnt != CW'(DEPTH));
        rem = pq.deq && !pq.enq && cnt != '0;
        rep = pq.enq && pq.deq && cnt != '0;
        bc = cnt - CW'(rem || rep);
    end
    // b is the array after popping slot 0 (if any); nx inserts kvi behind every key >= it.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        if (g < DEPTH - 1) begin : g_mid
            assign b[g] = (rem || rep) ? s[g+1] : s[g];
        end else begin : g_last
            assign b[g] = (rem || rep) ? '0 : s[g];
        end
        assign ahead[g] = (CW'(g) < bc) && !(pq.kvi.key > b[g].key);
        if (g == 0) begin : g_first
            assign nx[g] = ahead[g] ? b[g] : pq.kvi;
        end else begin : g_rest
            assign nx[g] = ahead[g] ? b[g] : ahead[g-1] ? pq.kvi : b[g-1];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '{default: '0};
            cnt <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (ins || rep) s <= nx;
            else if (rem) s <= b;
            cnt <= ins ? cnt + CW'(1) : rem ? cnt - CW'(1) : cnt;
            ovf_q <= pq.enq && !pq.deq && cnt == CW'(DEPTH);
            udf_q <= pq.deq && cnt == '0;
        end
    end
    assign pq.kvo = s[0];
    assign pq.count = cnt;
    assign pq.full = cnt == CW'(DEPTH);
    assign pq.empty = cnt == '0;
    assign pq.ovf = ovf_q;
    assign pq.udf = udf_q;
endmodule

// File: tb/tb_ra_pq_ctrl.sv
// tb_ra_pq_ctrl: directed and random operations checked against a sorted-queue reference model.
module tb_ra_pq_ctrl;
    import pq_pkg::*;
    localparam int DEPTH = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    ra_pq_ctrl_if #(.DEPTH(DEPTH)) pq ();
    ra_pq_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .pq(pq));
    kv_t q[$];
    int errs = 0;
    int checks = 0;
    logic exp_ovf = 1'b0;
    logic exp_udf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic kv_t mk(input int k, input int v);
        kv_t r;
        r.key = k[7:0];
        r.value = v[7:0];
        return r;
    endfunction

    task automatic verify();
        kv_t top;
        top = (q.size() != 0) ? q[0] : '0;
        chk("count", 32'(pq.count), q.size());
        chk("empty", 32'(pq.empty), 32'(q.size() == 0));
        chk("full", 32'(pq.full), 32'(q.size() == DEPTH));
        chk("kvo", 32'(pq.kvo), 32'(top));
        chk("ovf", 32'(pq.ovf), 32'(exp_ovf));
        chk("udf", 32'(pq.udf), 32'(exp_udf));
    endtask

    task automatic model_ins(input kv_t kv);
        int p;
        p = q.size();
        for (int i = 0; i < q.size(); i++)
            if (q[i].key < kv.key) begin
                p = i;
                break;
            end
        q.insert(p, kv);
    endtask

    task automatic op(input logic e, input logic d, input kv_t kv);
        pq.enq = e;
        pq.deq = d;
        pq.kvi = kv;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        if (e && d) begin
            if (q.size() == 0) exp_udf = 1'b1;
            else void'(q.pop_front());
            model_ins(kv);
        end else if (e) begin
            if (q.size() == DEPTH) exp_ovf = 1'b1;
            else model_ins(kv);
        end else if (d) begin
            if (q.size() == 0) exp_udf = 1'b1;
            else void'(q.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
        verify();
    endtask

    initial begin
        pq.enq = 1'b0;
        pq.deq = 1'b0;
        pq.kvi = '0;
        @(negedge clk);
        @(negedge clk);
        verify();
        rst = 1'b0;
        op(0, 0, '0);
        op(1, 0, mk(5, 1));
        op(1, 0, mk(9, 2));
        op(1, 0, mk(2, 3));
        op(1, 0, mk(7, 4));
        chk("top9", 32'(pq.kvo), 32'(mk(9, 2)));
        repeat (4) op(0, 1, '0);
        op(1, 0, mk(4, 'hA));
        op(1, 0, mk(4, 'hB));
        op(1, 0, mk(4, 'hC));
        op(0, 1, '0);
        chk("tieB", 32'(pq.kvo.value), 32'h0B);
        repeat (2) op(0, 1, '0);
        for (int k = 1; k <= 8; k++) op(1, 0, mk(k, k));
        op(1, 0, mk(20, 7));
        chk("ovf_top", 32'(pq.kvo.key), 32'd8);
        op(1, 1, mk(20, 7));
        chk("rep_top", 32'(pq.kvo.key), 32'd20);
        repeat (8) op(0, 1, '0);
        op(0, 1, '0);
        op(1, 1, mk(3, 9));
        op(0, 1, '0);
        op(1, 0, mk(10, 1));
        op(1, 0, mk(6, 2));
        op(1, 0, mk(3, 3));
        op(1, 1, mk(1, 4));
        chk("rep_low", 32'(pq.kvo.key), 32'd6);
        pq.enq = 1'b1;
        pq.deq = 1'b0;
        pq.kvi = mk(12, 5);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        q.delete();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        verify();
        rst = 1'b0;
        for (int n = 0; n < 3000; n++)
            op($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
               mk($urandom_range(0, 15), $urandom_range(0, 255)));
        op(0, 0, '0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
